// File: rtl/gb_interrupt_ctrl.sv
// Interrupt flag/enable controller for a Game Boy style CPU.
// Rising edges on the peripheral request lines set flag bits.
// The CPU reads and writes IF/IE over the memory bus and acknowledges
// the highest-priority pending source.
// The controller reports a pending flag and the ISR vector address.
module gb_interrupt_ctrl #(
    parameter int          NUM_IRQ = 5,
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        addr,
    input  logic [7:0]         data_i,
    input  logic               wren,
    output logic [7:0]         data_o,
    output logic               hit,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               clear_interrupt_flag,
    output logic [7:0]         reg_IF,
    output logic [7:0]         reg_IE,
    output logic               irq_pending,
    output logic [15:0]        irq_vector
);

    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [NUM_IRQ-1:0] rise;
    logic               hit_if, hit_ie;
    logic [7:0]         if_full;

    assign hit_if = (addr == IF_ADDR);
    assign hit_ie = (addr == IE_ADDR);
    assign hit    = hit_if | hit_ie;
    assign pend   = if_q & ie_q[NUM_IRQ-1:0];
    assign rise   = irq_i & ~irq_prev_q;

    // Unimplemented flag bits read back as ones.
    always_comb begin
        if_full                = 8'hFF;
        if_full[NUM_IRQ-1:0]   = if_q;
    end

    assign reg_IF = if_full;
    assign reg_IE = ie_q;

    // Priority pick: the lowest index wins. This drives both the ack mask and the vector.
    always_comb begin
        logic found;
        found       = 1'b0;
        ack_mask    = '0;
        irq_vector  = 16'h0000;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && !found) begin
                found       = 1'b1;
                ack_mask[i] = 1'b1;
                irq_vector  = 16'h0040 + 16'(i * 8);
            end
        end
        irq_pending = found;
    end

    // Bus read mux.
    always_comb begin
        data_o = 8'hFF;
        if (hit_if)
            data_o = if_full;
        else if (hit_ie)
            data_o = ie_q;
    end

    // Next state. A CPU write beats an ack in the same cycle. New edges are ORed in last, so they always win.
    always_comb begin
        if_d       = if_q;
        ie_d       = ie_q;
        irq_prev_d = irq_i;
        if (wren && hit_if)
            if_d = data_i[NUM_IRQ-1:0];
        else if (clear_interrupt_flag)
            if_d = if_q & ~ack_mask;
        if_d = if_d | rise;
        if (wren && hit_ie)
            ie_d = data_i;
    end

    // State registers. irq_prev clears on reset, so a line that is already high counts as an edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_q       <= '0;
            ie_q       <= 8'h00;
            irq_prev_q <= '0;
        end else begin
            if_q       <= if_d;
            ie_q       <= ie_d;
            irq_prev_q <= irq_prev_d;
        end
    end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Directed, table-driven bench for gb_interrupt_ctrl.
// The main instance uses NUM_IRQ=5 and a second instance uses NUM_IRQ=8.
module tb_gb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  data_i;
    logic        wren;
    logic [7:0]  data_o;
    logic        hit;
    logic [4:0]  irq_i;
    logic        clr;
    logic [7:0]  reg_if, reg_ie;
    logic        irq_pending;
    logic [15:0] irq_vector;

    logic        reset8;
    logic [15:0] addr8;
    logic [7:0]  data_i8;
    logic        wren8;
    logic [7:0]  data_o8;
    logic        hit8;
    logic [7:0]  irq_i8;
    logic        clr8;
    logic [7:0]  reg_if8, reg_ie8;
    logic        irq_pending8;
    logic [15:0] irq_vector8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gb_interrupt_ctrl #(.NUM_IRQ(5)) u_dut (
        .clk(clk), .reset(reset), .addr(addr), .data_i(data_i), .wren(wren),
        .data_o(data_o), .hit(hit), .irq_i(irq_i), .clear_interrupt_flag(clr),
        .reg_IF(reg_if), .reg_IE(reg_ie), .irq_pending(irq_pending),
        .irq_vector(irq_vector)
    );

    gb_interrupt_ctrl #(.NUM_IRQ(8)) u_dut8 (
        .clk(clk), .reset(reset8), .addr(addr8), .data_i(data_i8), .wren(wren8),
        .data_o(data_o8), .hit(hit8), .irq_i(irq_i8), .clear_interrupt_flag(clr8),
        .reg_IF(reg_if8), .reg_IE(reg_ie8), .irq_pending(irq_pending8),
        .irq_vector(irq_vector8)
    );

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [4:0]  irq;
        logic        clr;
        logic [7:0]  e_if;
        logic [7:0]  e_ie;
        logic        e_pend;
        logic [15:0] e_vec;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       input logic [4:0] irq, input logic c, input logic [7:0] e_if,
                       input logic [7:0] e_ie, input logic e_pend, input logic [15:0] e_vec);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.irq = irq; v.clr = c;
        v.e_if = e_if; v.e_ie = e_ie; v.e_pend = e_pend; v.e_vec = e_vec;
        tbl.push_back(v);
    endtask

    // Applies one cycle of stimulus at the falling edge. Results are sampled 1 time unit after the next rising edge.
    task automatic step(input logic wr, input logic [15:0] a, input logic [7:0] d,
                        input logic [4:0] irq, input logic c);
        @(negedge clk);
        wren = wr; addr = a; data_i = d; irq_i = irq; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; wren = 1'b0; clr = 1'b0; addr = 16'h0000; data_i = 8'h00; irq_i = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // wr  addr      data   irq      clr   IF     IE     pend  vector
        add(1, 16'hFFFF, 8'h04, 5'h00, 0, 8'hE0, 8'h04, 0, 16'h0000);
        add(0, 16'h0000, 8'h00, 5'h04, 0, 8'hE4, 8'h04, 1, 16'h0050);
        add(0, 16'h0000, 8'h00, 5'h00, 0, 8'hE4, 8'h04, 1, 16'h0050);
        add(1, 16'hFFFF, 8'h1F, 5'h00, 0, 8'hE4, 8'h1F, 1, 16'h0050);
        add(0, 16'h0000, 8'h00, 5'h01, 0, 8'hE5, 8'h1F, 1, 16'h0040);
        add(0, 16'h0000, 8'h00, 5'h00, 1, 8'hE4, 8'h1F, 1, 16'h0050);
        add(0, 16'h0000, 8'h00, 5'h00, 1, 8'hE0, 8'h1F, 0, 16'h0000);
        add(1, 16'hFF0F, 8'hFB, 5'h00, 0, 8'hFB, 8'h1F, 1, 16'h0040);
        add(1, 16'hFFFF, 8'h00, 5'h00, 0, 8'hFB, 8'h00, 0, 16'h0000);
        add(0, 16'h0000, 8'h00, 5'h00, 1, 8'hFB, 8'h00, 0, 16'h0000);
        add(1, 16'hFFFF, 8'h18, 5'h00, 0, 8'hFB, 8'h18, 1, 16'h0058);
        add(0, 16'h0000, 8'h00, 5'h00, 1, 8'hF3, 8'h18, 1, 16'h0060);
        add(1, 16'hFF0F, 8'h00, 5'h02, 1, 8'hE2, 8'h18, 0, 16'h0000);
        add(1, 16'hFF0F, 8'h00, 5'h02, 0, 8'hE0, 8'h18, 0, 16'h0000);
        add(0, 16'h0000, 8'h00, 5'h02, 0, 8'hE0, 8'h18, 0, 16'h0000);
        add(0, 16'h0000, 8'h00, 5'h00, 0, 8'hE0, 8'h18, 0, 16'h0000);
        add(0, 16'h0000, 8'h00, 5'h02, 0, 8'hE2, 8'h18, 0, 16'h0000);
        add(1, 16'hFFFF, 8'hFF, 5'h12, 0, 8'hF2, 8'hFF, 1, 16'h0048);
        add(1, 16'hFF0F, 8'h10, 5'h00, 0, 8'hF0, 8'hFF, 1, 16'h0060);
        add(1, 16'hFFFF, 8'hE0, 5'h00, 0, 8'hF0, 8'hE0, 0, 16'h0000);
        add(1, 16'hFF0F, 8'h00, 5'h00, 0, 8'hE0, 8'hE0, 0, 16'h0000);
        add(1, 16'hFF0F, 8'h00, 5'h10, 0, 8'hF0, 8'hE0, 0, 16'h0000);
        add(1, 16'hFFFF, 8'hFF, 5'h00, 0, 8'hF0, 8'hFF, 1, 16'h0060);
        add(0, 16'h0000, 8'h00, 5'h10, 1, 8'hF0, 8'hFF, 1, 16'h0060);

        reset = 1'b1; wren = 1'b0; clr = 1'b0; addr = 16'h0000; data_i = 8'h00; irq_i = '0;
        reset8 = 1'b1; wren8 = 1'b0; clr8 = 1'b0; addr8 = 16'h0000; data_i8 = 8'h00; irq_i8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_if", 16'(reg_if), 16'h00E0);
        check("rst_ie", 16'(reg_ie), 16'h0000);
        check("rst_pend", 16'(irq_pending), 16'h0000);
        check("rst_vec", irq_vector, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].irq, tbl[i].clr);
            check($sformatf("v%0d_if", i), 16'(reg_if), 16'(tbl[i].e_if));
            check($sformatf("v%0d_ie", i), 16'(reg_ie), 16'(tbl[i].e_ie));
            check($sformatf("v%0d_pend", i), 16'(irq_pending), 16'(tbl[i].e_pend));
            check($sformatf("v%0d_vec", i), irq_vector, tbl[i].e_vec);
        end

        // Bus reads. IF=F0 and IE=FF are left over from the table.
        step(0, 16'hFF0F, 8'h00, 5'h00, 0);
        check("rd_if", 16'(data_o), 16'h00F0);
        check("rd_if_hit", 16'(hit), 16'h0001);
        addr = 16'hFFFF; #1;
        check("rd_ie", 16'(data_o), 16'h00FF);
        check("rd_ie_hit", 16'(hit), 16'h0001);
        addr = 16'h1234; #1;
        check("rd_miss", 16'(data_o), 16'h00FF);
        check("rd_miss_hit", 16'(hit), 16'h0000);

        // An asynchronous reset mid-pending clears state without a clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_if", 16'(reg_if), 16'h00E0);
        check("arst_ie", 16'(reg_ie), 16'h0000);
        check("arst_pend", 16'(irq_pending), 16'h0000);
        check("arst_vec", irq_vector, 16'h0000);

        // A level high at reset release counts as an edge on the first clock.
        irq_i = 5'h01;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_before", 16'(reg_if), 16'h00E0);
        @(posedge clk);
        #1;
        check("rel_edge", 16'(reg_if), 16'h00E1);

        // A level held high sets the flag once. After a write clears it, the flag stays clear until the line re-arms.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) step(1, 16'hFF0F, 8'h00, 5'h08, 0);
            else        step(0, 16'h0000, 8'h00, 5'h08, 0);
            check($sformatf("hold_c%0d", c), 16'(reg_if), (c < 5) ? 16'h00E8 : 16'h00E0);
        end
        step(0, 16'h0000, 8'h00, 5'h00, 0);
        check("hold_low", 16'(reg_if), 16'h00E0);
        step(0, 16'h0000, 8'h00, 5'h08, 0);
        check("hold_rearm", 16'(reg_if), 16'h00E8);

        // Checks for the eight-source instance.
        @(negedge clk);
        reset8 = 1'b0;
        addr8 = 16'hFF0F;
        #1;
        check("n8_rd_if", 16'(data_o8), 16'h0000);
        check("n8_hit", 16'(hit8), 16'h0001);
        addr8 = 16'h1234; #1;
        check("n8_miss", 16'(data_o8), 16'h00FF);
        check("n8_miss_hit", 16'(hit8), 16'h0000);
        @(negedge clk);
        wren8 = 1'b1; addr8 = 16'hFFFF; data_i8 = 8'hFF; irq_i8 = 8'h80;
        @(posedge clk);
        #1;
        check("n8_if7", 16'(reg_if8), 16'h0080);
        check("n8_vec7", irq_vector8, 16'h0078);
        @(negedge clk);
        wren8 = 1'b0;
        #2 reset8 = 1'b1;
        #1;
        check("n8_arst_if", 16'(reg_if8), 16'h0000);
        check("n8_arst_pend", 16'(irq_pending8), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gb_interrupt_ctrl.md
GB_INTERRUPT_CTRL -- requirements
Module: gb_interrupt_ctrl

Interface
REQ-001: Parameter NUM_IRQ, default 5, number of interrupt sources; legal range 1..8.
REQ-002: Parameter IF_ADDR, default 16'hFF0F, bus address of the interrupt flag register.
REQ-003: Parameter IE_ADDR, default 16'hFFFF, bus address of the interrupt enable register.
REQ-004: clk  input  1  single system clock; all state updates on its rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: addr  input  16  CPU address bus.
REQ-007: data_i  input  8  CPU write data.
REQ-008: wren  input  1  CPU write strobe, qualified by addr.
REQ-009: data_o  output  8  read data for addr (combinational).
REQ-010: hit  output  1  high when addr equals IF_ADDR or IE_ADDR.
REQ-011: irq_i  input  NUM_IRQ  level request lines from peripherals; bit 0 has the highest priority.
REQ-012: clear_interrupt_flag  input  1  CPU acknowledge pulse from the ISR dispatch.
REQ-013: reg_IF  output  8  current flag register value as read by the CPU.
REQ-014: reg_IE  output  8  current enable register value.
REQ-015: irq_pending  output  1  high when (IF & IE) over the implemented bits is nonzero.
REQ-016: irq_vector  output  16  ISR address of the highest-priority pending source.

Function
REQ-017: IF SHALL hold NUM_IRQ flag bits; unimplemented bits [7:NUM_IRQ] read as 1 on reg_IF and data_o, and writes to them are ignored.
REQ-018: IE SHALL be a full 8-bit read/write register; only bits [NUM_IRQ-1:0] participate in pending and priority.
REQ-019: Each irq_i bit SHALL be edge-detected against a registered copy of itself (irq_prev); a rising edge sets the corresponding IF bit, visible on reg_IF on the clock edge following the sampled rise.
REQ-020: A level held high SHALL set IF only once; re-arming requires irq_i to return low for at least one cycle.
REQ-021: A write with wren=1 to IF_ADDR SHALL load IF[NUM_IRQ-1:0] from data_i[NUM_IRQ-1:0] on the next edge.
REQ-022: A write with wren=1 to IE_ADDR SHALL load IE from data_i on the next edge.
REQ-023: clear_interrupt_flag=1 SHALL clear only the lowest-indexed bit set in (IF & IE); if that set is empty, IF is unchanged.
REQ-024: Per-cycle update order SHALL be: CPU write to IF, else acknowledge clear; then OR in new edge sets.
REQ-025: A write to IF in the same cycle as clear_interrupt_flag SHALL take precedence, and the clear is discarded.
REQ-026: A new edge on a bit SHALL win over a same-cycle clear or a write of 0 to that bit.
REQ-027: data_o SHALL be {1s, IF} at IF_ADDR, IE at IE_ADDR, and 8'hFF otherwise; hit is 0 otherwise.
REQ-028: irq_vector SHALL be 16'h0040 + 8*k, where k is the lowest index set in (IF & IE).
REQ-029: irq_vector SHALL be 16'h0000 when irq_pending=0.
REQ-030: irq_pending and irq_vector SHALL be combinational from the registered IF and IE values, with no added latency.

Reset
REQ-031: Asserting reset SHALL immediately force IF=0, IE=0, and irq_prev=0, regardless of clk.
REQ-032: With NUM_IRQ=5, reg_IF reads 8'hE0 and reg_IE reads 8'h00 during reset.
REQ-033: irq_pending=0 and irq_vector=16'h0000 during reset.
REQ-034: An irq_i line high at reset release SHALL be treated as a rising edge and set its IF bit on the first clock after release.
REQ-035: Reset asserted mid-operation SHALL discard pending flags and any in-flight write or clear.

Verification
REQ-036: NUM_IRQ=5, IE=8'h04, pulse irq_i[2] for 1 cycle -> reg_IF=8'hE4 next cycle, irq_pending=1, irq_vector=16'h0050.
REQ-037: IF=8'h05 set, IE=8'h1F, then clear_interrupt_flag pulse -> reg_IF=8'hE4, irq_vector moves from 16'h0040 to 16'h0050.
REQ-038: IF bit0 set, IE=8'h00, then clear pulse -> IF unchanged and irq_pending=0.
REQ-039: Same cycle: write IF_ADDR with 8'h00, clear pulse, and irq_i[1] rising -> reg_IF=8'hE2.
REQ-040: irq_i[3] held high for 10 cycles, CPU writes IF=0 at cycle 5 -> bit3 stays 0 until irq_i falls and rises again.
REQ-041: NUM_IRQ=8 -> read IF_ADDR after reset gives 8'h00; read 16'h1234 gives 8'hFF with hit=0; async reset mid-pending clears IF without a clock edge.
